// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch port.
package imem_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned PC_MAX_W = 64;

    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10
    } fault_e;

    // Byte address to word index.
    function automatic logic [PC_MAX_W-1:0] word_index(input logic [PC_MAX_W-1:0] pc);
        return pc >> 2;
    endfunction

    function automatic logic word_in_range(input logic [PC_MAX_W-1:0] pc,
                                           input int unsigned          depth);
        return word_index(pc) < PC_MAX_W'(depth);
    endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response handshake between the fetch stage (master) and the instruction memory (slave).
interface imem_fetch_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_inst;
    logic [ADDR_W-1:0] rsp_pc;
    logic [1:0]        rsp_fault;
    logic              flush;

    modport master (
        output req_valid, req_pc, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
    );
endinterface

// File: rtl/imem_array.sv
// Word-organised instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data_c
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive reset; the loader may write while the core is held.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a registered valid/ready fetch port, loader write port and fault reporting.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LD_AW       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    imem_fetch_if.slave      bus,
    input  logic             ld_en,
    input  logic [LD_AW-1:0] ld_addr,
    input  logic [31:0]      ld_data
);

    logic              rsp_valid_q;
    logic [31:0]       rsp_inst_q;
    logic [ADDR_W-1:0] rsp_pc_q;
    fault_e            rsp_fault_q;

    logic              req_ready_c;
    logic              accept_c;
    logic [LD_AW-1:0]  rd_addr_c;
    logic [31:0]       rd_data_c;
    fault_e            fault_c;
    logic [31:0]       inst_c;

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (LD_AW)
    ) u_array (
        .clk       (clk),
        .wr_en     (ld_en),
        .wr_addr   (ld_addr),
        .wr_data   (ld_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    // A slot opens when empty, when the held word retires, or when it is flushed.
    assign req_ready_c = reset & ~ld_en & (~rsp_valid_q | bus.rsp_ready | bus.flush);
    assign accept_c    = bus.req_valid & req_ready_c;
    assign rd_addr_c   = LD_AW'(word_index(PC_MAX_W'(bus.req_pc)));

    // Misaligned wins over out-of-range; any fault substitutes a NOP.
    always_comb begin
        fault_c = FLT_NONE;
        inst_c  = rd_data_c;
        if (bus.req_pc[1:0] != 2'b00) begin
            fault_c = FLT_MISALIGN;
            inst_c  = NOP_INST;
        end else if (!word_in_range(PC_MAX_W'(bus.req_pc), DEPTH_WORDS)) begin
            fault_c = FLT_RANGE;
            inst_c  = NOP_INST;
        end
    end

    // Response register: accept loads, retire or flush empties, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= '0;
            rsp_pc_q    <= '0;
            rsp_fault_q <= FLT_NONE;
        end else if (accept_c) begin
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= inst_c;
            rsp_pc_q    <= bus.req_pc;
            rsp_fault_q <= fault_c;
        end else if (rsp_valid_q && (bus.rsp_ready || bus.flush)) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_inst  = rsp_inst_q;
    assign bus.rsp_pc    = rsp_pc_q;
    assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, word-organised instruction memory with a registered valid/ready fetch port, a loader write port and fault reporting. It replaces the combinational byte-array instruction store between the PC/fetch stage and decode: the fetch stage issues a PC, and one cycle later the block returns the little-endian 32-bit instruction word tagged with its PC and a fault code. The loader port preloads program images, including while the core is held in reset. A flush input discards a stale response on a branch redirect.

## Interface
- ADDR_W, 32: width of PC / byte address.
- DEPTH_WORDS, 64: number of 32-bit words; power of two, ≥ 2.
- LD_AW, $clog2(DEPTH_WORDS): loader word-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block accepts request this cycle.
- req_pc  in  ADDR_W  byte address of instruction.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes response.
- rsp_inst  out  32  instruction word, {B3,B2,B1,B0}, where B0 is at the lowest byte address.
- rsp_pc  out  ADDR_W  PC of the held response.
- rsp_fault  out  2  00 OK, 01 misaligned, 10 out-of-range.
- flush  in  1  discard the held response.
- ld_en  in  1  loader write strobe.
- ld_addr  in  LD_AW  loader word index.
- ld_data  in  32  loader word.

## Operation
- Storage: DEPTH_WORDS × 32 array. Contents are not cleared by reset and are undefined until loaded.
- Loader:
  - When ld_en=1, mem[ld_addr] ← ld_data at the clock edge.
  - The loader is honoured whether reset is 0 or 1.
- req_ready = reset & ~ld_en & (~rsp_valid | rsp_ready | flush).
- Accept: req_valid & req_ready. At the next edge, the response register loads rsp_pc=req_pc and sets rsp_valid=1.
- Fault classification, evaluated on req_pc at accept:
  - If req_pc[1:0] ≠ 0, rsp_fault=01 (misaligned).
  - Else if req_pc[ADDR_W-1:2] ≥ DEPTH_WORDS, rsp_fault=10 (out-of-range).
  - Else rsp_fault=00 and rsp_inst=mem[req_pc[2+LD_AW-1:2]].
  - Misaligned has priority over out-of-range.
  - Any fault returns rsp_inst=NOP_INST (32'h00000013). The array is not read.
- Hold: while rsp_valid & ~rsp_ready & ~flush, rsp_inst, rsp_pc and rsp_fault are stable. A loader write to the held word does not alter rsp_inst; data is captured at accept.
- Retire: rsp_valid & rsp_ready with no new accept clears rsp_valid at the next edge.
- Back-to-back: retire and accept in the same cycle gives continuous rsp_valid=1, one word per cycle.
- Flush:
  - Flush drops the held response: rsp_valid=0 at the next edge unless a request is accepted in the flush cycle.
  - A request accepted in the flush cycle is the redirect target. It is kept and appears next cycle.
  - Flush with rsp_valid=0 has no effect.
- Loader and fetch are mutually exclusive: req_ready=0 while ld_en=1. A response already held stays held and can still retire.

## Timing
- Fetch latency: 1 cycle, accept edge → rsp_valid. Throughput: 1 word/cycle.
- No combinational path from req_* to rsp_*. req_ready depends combinationally on rsp_ready, flush and ld_en.
- Reset (reset=0 at an edge):
  - rsp_valid=0, rsp_inst=0, rsp_pc=0, rsp_fault=00.
  - req_ready=0 while reset=0.
  - Reset mid-response drops the response. The array is preserved.
- Loader write visible to a fetch accepted on the cycle after the write edge.

## Structure
- Package imem_pkg holds:
  - NOP_INST = 32'h00000013.
  - Fault enum: FLT_NONE=2'b00, FLT_MISALIGN=2'b01, FLT_RANGE=2'b10.
  - Helper functions for the word index and range check.
- Sub-module imem_array: DEPTH_WORDS × 32, one synchronous write port, one asynchronous read port (read captured into the response register by the parent). It can later be swapped for a synchronous SRAM macro, with latency rebalanced in the parent.
- Parent imem_fetch_port holds the handshake, fault classification, response register and flush logic.

## Test plan
- Preload words 0..7 via the loader with reset=0, release reset, fetch PC 0,4,…,28 back-to-back with rsp_ready=1 → rsp_inst matches the loaded words in order, one per cycle, with rsp_valid continuous from the 2nd cycle.
- Fetch PC 0x6 → rsp_fault=01, rsp_inst=0x00000013. Fetch PC 0x100 with DEPTH_WORDS=64 → rsp_fault=10, rsp_inst=0x00000013. Fetch PC 0x102 → rsp_fault=01.
- Backpressure: rsp_ready=0 for 3 cycles with PC 8 held → outputs stable and req_ready=0. rsp_ready=1 → retires. A new request accepted in that same cycle appears next cycle.
- Flush with a held response at PC 0x10 while a request at PC 0x40 is accepted → next cycle rsp_pc=0x40. The 0x10 response is never seen.
- Loader to word 2 while its response is held → rsp_inst unchanged, req_ready=0 during ld_en. A re-fetch of PC 8 returns the new data.
- Assert reset=0 with rsp_valid=1 → next edge all outputs 0. After release, a fetch of PC 0 returns the pre-reset memory content.
